// File: rtl/fb_capture_pkg.sv
// Shared types and constants for the feedback DAC capture buffer.
// Default sample width, FSM state encoding and magnitude saturation limit.
package fb_capture_pkg;

  localparam int FB_DW = 13;

  localparam logic [FB_DW-1:0] DW_MAX_POS = (FB_DW)'((1 << (FB_DW - 1)) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } fbcap_state_t;

endpackage

// File: rtl/fbcap_ram.sv
// Simple dual-port sample buffer for the capture block.
// Synchronous write, registered read with a resettable output register.
module fbcap_ram
  import fb_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = FB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_output_capture.sv
// Per-pulse capture of the feedback DAC word inside one store_strb window,
// followed by a valid/ready readout of the stored samples.
module fb_output_capture
  import fb_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = FB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          store_strb,
  input  logic          fb_valid,
  input  logic [DW-1:0] fb_sgnl,
  input  logic          oflow,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   sample_count,
  output logic          trunc,
  output logic          oflow_seen,
  output logic [DW-1:0] max_abs
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] MAG_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAG_MIN = {1'b1, {(DW-1){1'b0}}};

  fbcap_state_t  state;
  logic          strb_q;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mag;
  logic          take;
  logic          wr_en;
  logic          rd_en;
  logic          xfer;

  assign busy  = (state != ST_IDLE);
  assign take  = (state == ST_CAPTURE) && store_strb && fb_valid;
  assign wr_en = take && (sample_count != FULL);
  assign xfer  = rd_valid && rd_ready;
  // Fetch the next word whenever the output register is empty or draining.
  assign rd_en = (state == ST_READOUT) && (rd_ptr != sample_count) &&
                 (!rd_valid || rd_ready);

  // The most negative code has no positive twin; clamp it.
  always_comb begin
    mag = fb_sgnl;
    if (fb_sgnl[DW-1]) mag = (fb_sgnl == MAG_MIN) ? MAG_MAX : -fb_sgnl;
  end

  fbcap_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(sample_count[AW-1:0]),
    .wdata(fb_sgnl),
    .re   (rd_en),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      strb_q       <= 1'b0;
      rd_ptr       <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      trunc        <= 1'b0;
      oflow_seen   <= 1'b0;
      max_abs      <= '0;
    end else begin
      strb_q <= store_strb;
      done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arm) begin
            state        <= ST_ARMED;
            rd_ptr       <= '0;
            sample_count <= '0;
            trunc        <= 1'b0;
            oflow_seen   <= 1'b0;
            max_abs      <= '0;
          end
        end
        ST_ARMED: begin
          if (store_strb && !strb_q) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (wr_en) begin
            sample_count <= sample_count + 1'b1;
            if (mag > max_abs) max_abs <= mag;
          end
          if (take && !wr_en) trunc      <= 1'b1;
          if (oflow)          oflow_seen <= 1'b1;
          if (!store_strb) begin
            state <= ST_READOUT;
            done  <= 1'b1;
          end
        end
        ST_READOUT: begin
          if (rd_en) begin
            rd_valid <= 1'b1;
            rd_last  <= (rd_ptr == sample_count - 1'b1);
            rd_ptr   <= rd_ptr + 1'b1;
          end else if (xfer) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
          if ((sample_count == '0) || (xfer && rd_last)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_output_capture.sv
// Scoreboard bench for fb_output_capture: capture windows, truncation,
// backpressure, empty window, overflow flag and reset recovery.
module tb_fb_output_capture;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic          store_strb;
  logic          fb_valid;
  logic [DW-1:0] fb_sgnl;
  logic          oflow;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [AW:0]   sample_count;
  logic          trunc;
  logic          oflow_seen;
  logic [DW-1:0] max_abs;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } item_t;

  item_t         exp_q[$];
  int            exp_count;
  logic [DW-1:0] exp_max;
  logic          exp_trunc;
  logic          exp_oflow;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  fb_output_capture #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .store_strb  (store_strb),
    .fb_valid    (fb_valid),
    .fb_sgnl     (fb_sgnl),
    .oflow       (oflow),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .sample_count(sample_count),
    .trunc       (trunc),
    .oflow_seen  (oflow_seen),
    .max_abs     (max_abs)
  );

  function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] x);
    if (x == 13'h1000) return 13'd4095;
    if (x[DW-1]) return 13'(-x);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_block();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_count = 0;
    exp_max   = '0;
    exp_trunc = 1'b0;
    exp_oflow = 1'b0;
  endtask

  task automatic open_window();
    store_strb = 1'b1;
    tick();
  endtask

  task automatic cap_cycle(input bit v, input logic [DW-1:0] x, input bit of);
    fb_valid = v;
    fb_sgnl  = x;
    oflow    = of;
    tick();
    fb_valid = 1'b0;
    oflow    = 1'b0;
    if (v) begin
      if (exp_count < DEPTH) begin
        exp_q.push_back('{data: x, last: 1'b0});
        exp_count++;
        if (mag_of(x) > exp_max) exp_max = mag_of(x);
      end else begin
        exp_trunc = 1'b1;
      end
    end
    if (of) exp_oflow = 1'b1;
  endtask

  task automatic close_window();
    store_strb = 1'b0;
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    tick();
  endtask

  task automatic drain(input bit bp, input string tag);
    logic [DW-1:0] hd;
    logic          hl;
    bit            st;
    int            cyc;
    item_t         it;
    st  = 1'b0;
    hd  = '0;
    hl  = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      if (st) begin
        n_checks++;
        if (!(rd_valid === 1'b1 && rd_data === hd && rd_last === hl)) begin
          n_fail++;
          $display("FAIL %s stall_hold: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b",
                   tag, rd_valid, rd_data, rd_last, hd, hl);
        end
      end
      if (rd_valid && rd_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s rd_extra: got d=%h with no sample expected", tag, rd_data);
        end else begin
          it = exp_q.pop_front();
          if (rd_data !== it.data || rd_last !== it.last) begin
            n_fail++;
            $display("FAIL %s rd_word: got d=%h l=%0b, need d=%h l=%0b",
                     tag, rd_data, rd_last, it.data, it.last);
          end
        end
      end
      st = rd_valid && !rd_ready;
      hd = rd_data;
      hl = rd_last;
      tick();
      cyc++;
    end
    rd_ready = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain_timeout: busy=%0b after %0d cycles, need 0", tag, busy, cyc);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s lost: %0d samples never read, need 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({rd_valid, rd_data, rd_last, busy, done, sample_count, trunc,
         oflow_seen, max_abs} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, need 0", {rd_valid, rd_data, rd_last,
               busy, done, sample_count, trunc, oflow_seen, max_abs});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [4];
    vals[0] = 13'd100;
    vals[1] = -13'sd200;
    vals[2] = 13'd4095;
    vals[3] = 13'h1000;
    arm_block();
    open_window();
    for (int i = 0; i < 40; i++)
      cap_cycle((i % 10) == 9, vals[i / 10], 1'b0);
    n_checks++;
    if (sample_count !== 5'd4) begin
      n_fail++;
      $display("FAIL basic_count_live: got %0d, need 4", sample_count);
    end
    close_window();
    n_checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_F1: got done=%0b valid=%0b busy=%0b, need 1 0 1",
               done, rd_valid, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_F2: got done=%0b valid=%0b, need 0 1", done, rd_valid);
    end
    drain(1'b0, "basic");
    n_checks++;
    if (sample_count !== 5'd4 || max_abs !== 13'd4095 || trunc !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got cnt=%0d max=%0d trunc=%0b, need 4 4095 0",
               sample_count, max_abs, trunc);
    end
  endtask

  task automatic test_truncation();
    arm_block();
    open_window();
    for (int i = 0; i < 30; i++) cap_cycle(1'b1, 13'(i * 150 - 2000), 1'b0);
    close_window();
    drain(1'b0, "trunc");
    n_checks++;
    if (sample_count !== 5'(exp_count) || trunc !== exp_trunc || max_abs !== exp_max) begin
      n_fail++;
      $display("FAIL trunc_result: got cnt=%0d trunc=%0b max=%0d, need %0d %0b %0d",
               sample_count, trunc, max_abs, exp_count, exp_trunc, exp_max);
    end
  endtask

  task automatic test_backpressure();
    arm_block();
    open_window();
    for (int i = 0; i < 24; i++) cap_cycle(i[0], 13'($urandom), 1'b0);
    close_window();
    drain(1'b1, "bp");
    n_checks++;
    if (sample_count !== 5'(exp_count) || max_abs !== exp_max) begin
      n_fail++;
      $display("FAIL bp_result: got cnt=%0d max=%0d, need %0d %0d",
               sample_count, max_abs, exp_count, exp_max);
    end
  endtask

  task automatic test_empty_window();
    bit saw_valid;
    saw_valid  = 1'b0;
    store_strb = 1'b1;
    tick();
    arm_block();
    fb_valid = 1'b1;
    fb_sgnl  = 13'd77;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_valid |= rd_valid;
    end
    fb_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || sample_count !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_armed_hold: got busy=%0b cnt=%0d, need 1 0", busy, sample_count);
    end
    store_strb = 1'b0;
    tick();
    open_window();
    for (int i = 0; i < 5; i++) begin
      cap_cycle(1'b0, 13'd0, 1'b0);
      saw_valid |= rd_valid;
    end
    close_window();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_done: got %0b, need 1", done);
    end
    saw_valid |= rd_valid;
    tick();
    saw_valid |= rd_valid;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_idle: got busy=%0b done=%0b cnt=%0d, need 0 0 0",
               busy, done, sample_count);
    end
    tick();
    saw_valid |= rd_valid;
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL empty_no_valid: rd_valid seen=1, need 0");
    end
  endtask

  task automatic test_oflow();
    arm_block();
    open_window();
    cap_cycle(1'b1, 13'd5, 1'b0);
    cap_cycle(1'b0, 13'd0, 1'b1);
    cap_cycle(1'b1, -13'sd7, 1'b0);
    close_window();
    drain(1'b0, "oflow_cap");
    n_checks++;
    if (oflow_seen !== 1'b1 || max_abs !== 13'd7) begin
      n_fail++;
      $display("FAIL oflow_capture: got seen=%0b max=%0d, need 1 7", oflow_seen, max_abs);
    end
    arm_block();
    oflow = 1'b1;
    tick();
    oflow = 1'b0;
    open_window();
    cap_cycle(1'b1, 13'd3, 1'b0);
    cap_cycle(1'b1, 13'd9, 1'b0);
    close_window();
    drain(1'b0, "oflow_armed");
    n_checks++;
    if (oflow_seen !== exp_oflow) begin
      n_fail++;
      $display("FAIL oflow_armed_only: got %0b, need %0b", oflow_seen, exp_oflow);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    arm_block();
    open_window();
    for (int i = 0; i < 3; i++) cap_cycle(1'b1, 13'(i + 40), 1'b0);
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({rd_valid, rd_data, rd_last, busy, done, sample_count, trunc,
         oflow_seen, max_abs} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_in_capture: got %h, need 0", {rd_valid, rd_data, rd_last,
               busy, done, sample_count, trunc, oflow_seen, max_abs});
    end
    rst_n = 1'b1;
    store_strb = 1'b0;
    exp_q.delete();
    tick();
    arm_block();
    open_window();
    cap_cycle(1'b1, 13'd500, 1'b0);
    cap_cycle(1'b1, 13'd600, 1'b0);
    rd_ready = 1'b0;
    close_window();
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup_readout: rd_valid=%0b, need 1", rd_valid);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({rd_valid, rd_data, rd_last, busy, done, sample_count, trunc,
         oflow_seen, max_abs} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_in_readout: got %h, need 0", {rd_valid, rd_data, rd_last,
               busy, done, sample_count, trunc, oflow_seen, max_abs});
    end
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    exp_q.delete();
    tick();
    arm_block();
    open_window();
    cap_cycle(1'b1, -13'sd1234, 1'b0);
    cap_cycle(1'b1, 13'd321, 1'b0);
    cap_cycle(1'b1, 13'd1000, 1'b0);
    close_window();
    drain(1'b0, "rearm");
    n_checks++;
    if (sample_count !== 5'd3 || max_abs !== 13'd1234 || oflow_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_result: got cnt=%0d max=%0d seen=%0b, need 3 1234 0",
               sample_count, max_abs, oflow_seen);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    arm        = 1'b0;
    store_strb = 1'b0;
    fb_valid   = 1'b0;
    fb_sgnl    = '0;
    oflow      = 1'b0;
    rd_ready   = 1'b1;
    exp_count  = 0;
    exp_max    = '0;
    exp_trunc  = 1'b0;
    exp_oflow  = 1'b0;
    test_reset();
    test_basic();
    test_truncation();
    test_backpressure();
    test_empty_window();
    test_oflow();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
